// File: rtl/gate_self_test.sv
// -----------------------------------------------------------------------------
// gate_self_test
//
// Built-in self test for a small combinational gate block. The block under test
// sees a 4-bit vector on a/b/c/d and returns ten responses on obs. Each of the
// 16 vectors is applied, allowed to settle, then compared against the expected
// truth table. Failures are counted, and the first failing vector and its
// mismatch bits are recorded.
//
// Optional feature macro: GATE_CHECK_MASK_EN
//   When defined, a chk_mask input is added. Bits set in chk_mask are excluded
//   from the comparison. When undefined, there is no chk_mask port and all ten
//   bits are compared.
//
// Parameters
//   SETTLE_CYCLES   idle cycles between driving a vector and sampling obs (1..15)
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous active-high reset; aborts any run in progress
//   start            starts a run when sampled high in IDLE or DONE
//   chk_mask[9:0]    (GATE_CHECK_MASK_EN only) per-bit compare exclusion
//   obs[9:0]         gate responses, bit0 = o1 ... bit9 = o10
//   a, b, c, d       stimulus: vec[3], vec[2], vec[1], vec[0]; 0 when not busy
//   busy             high in APPLY / SETTLE / CHECK
//   done             high in DONE
//   pass             high in DONE when no vector failed
//   err_count[4:0]   failing vectors in the current or last run
//   first_fail_vec   index of the first failing vector
//   first_fail_mask  mismatch bits of the first failing vector
// -----------------------------------------------------------------------------
module gate_self_test #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef GATE_CHECK_MASK_EN
  input  logic [9:0] chk_mask,
`endif
  input  logic [9:0] obs,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail_vec,
  output logic [9:0] first_fail_mask
);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  // The settle counter is loaded with N-1 and counts down to 0, giving
  // exactly N cycles in SETTLE.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_vec;
  logic [3:0] r_settle_cnt;
  logic [3:0] r_abcd;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [4:0] r_err_count;
  logic [3:0] r_first_fail_vec;
  logic [9:0] r_first_fail_mask;

  logic       w_va;
  logic       w_vb;
  logic       w_vc;
  logic       w_vd;
  logic [9:0] w_expected;
  logic [9:0] w_mismatch;

  // Reference responses are derived from r_vec rather than from the output
  // pins. r_vec always equals the driven vector while a run is active.
  assign {w_va, w_vb, w_vc, w_vd} = r_vec;

  assign w_expected = {
    w_va & w_vb,                  // o10
    w_vc,                         // o9
    ~w_vd,                        // o8
    w_vc,                         // o7
    ~(w_vb ^ w_vd),               // o6
    w_va ^ w_vb ^ w_vc ^ w_vd,    // o5
    ~(w_vc | w_vd),               // o4
    w_va | w_vb | w_vc | w_vd,    // o3
    ~(w_va & w_vb),               // o2
    w_va & w_vb                   // o1
  };

`ifdef GATE_CHECK_MASK_EN
  assign w_mismatch = (obs ^ w_expected) & ~chk_mask;
`else
  assign w_mismatch = obs ^ w_expected;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= IDLE;
      r_vec             <= 4'd0;
      r_settle_cnt      <= 4'd0;
      r_abcd            <= 4'd0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_err_count       <= 5'd0;
      r_first_fail_vec  <= 4'd0;
      r_first_fail_mask <= 10'd0;
    end else begin
      case (r_state)
        // start is only honoured here, so it is ignored while busy.
        IDLE, DONE: begin
          if (start) begin
            r_state           <= APPLY;
            r_vec             <= 4'd0;
            r_abcd            <= 4'd0;
            r_busy            <= 1'b1;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_count       <= 5'd0;
            r_first_fail_vec  <= 4'd0;
            r_first_fail_mask <= 10'd0;
          end
        end

        APPLY: begin
          r_state      <= SETTLE;
          r_settle_cnt <= SETTLE_LAST;
        end

        SETTLE: begin
          if (r_settle_cnt == 4'd0) begin
            r_state <= CHECK;
          end else begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
          end
        end

        CHECK: begin
          if (w_mismatch != 10'd0) begin
            r_err_count <= r_err_count + 5'd1;
            if (r_err_count == 5'd0) begin
              r_first_fail_vec  <= r_vec;
              r_first_fail_mask <= w_mismatch;
            end
          end
          if (r_vec == 4'hF) begin
            // Last vector: pass must also account for this vector's result.
            r_state <= DONE;
            r_abcd  <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err_count == 5'd0) && (w_mismatch == 10'd0);
          end else begin
            r_state <= APPLY;
            r_vec   <= r_vec + 4'd1;
            r_abcd  <= r_vec + 4'd1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign {a, b, c, d}     = r_abcd;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err_count;
  assign first_fail_vec   = r_first_fail_vec;
  assign first_fail_mask  = r_first_fail_mask;

endmodule

// File: tb/tb_gate_self_test.sv
// -----------------------------------------------------------------------------
// tb_gate_self_test
//
// Two instances of gate_self_test run side by side: one with SETTLE_CYCLES=2
// and one with SETTLE_CYCLES=4. Each instance drives its own gate-block model.
// The model registers its outputs. A fault selector can force o5 to 0, or make
// o9 lag its sibling outputs by 3 extra cycles.
//
// Expected end-of-run results are pushed to a scoreboard queue when a run is
// started. They are popped and compared when the matching instance raises
// done. Cycle-exact checks on busy/done/stimulus are made inline.
// -----------------------------------------------------------------------------
module tb_gate_self_test;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
`ifdef GATE_CHECK_MASK_EN
  logic [9:0] chk_mask;
`endif

  logic       a2, b2, c2, d2, busy2, done2, pass2;
  logic [4:0] err2;
  logic [3:0] ffv2;
  logic [9:0] ffm2, obs2;

  logic       a4, b4, c4, d4, busy4, done4, pass4;
  logic [4:0] err4;
  logic [3:0] ffv4;
  logic [9:0] ffm4, obs4;

  // 0 = correct gate, 1 = o5 stuck at 0, 2 = o9 delayed
  logic [1:0] fault2, fault4;
  logic [2:0] dly2, dly4;

  gate_self_test #(.SETTLE_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start),
`ifdef GATE_CHECK_MASK_EN
    .chk_mask(chk_mask),
`endif
    .obs(obs2), .a(a2), .b(b2), .c(c2), .d(d2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_vec(ffv2), .first_fail_mask(ffm2)
  );

  gate_self_test #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start),
`ifdef GATE_CHECK_MASK_EN
    .chk_mask(chk_mask),
`endif
    .obs(obs4), .a(a4), .b(b4), .c(c4), .d(d4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
    .first_fail_vec(ffv4), .first_fail_mask(ffm4)
  );

  // Gate block under test: the truth table, a stuck-at option, and a slow o9.
  function automatic logic [9:0] gate_model(input logic [3:0] v, input logic [1:0] flt,
                                            input logic slow_c);
    logic ga, gb, gc, gd;
    logic [9:0] r;
    {ga, gb, gc, gd} = v;
    r = {ga & gb, gc, ~gd, gc, ~(gb ^ gd), ga ^ gb ^ gc ^ gd, ~(gc | gd),
         ga | gb | gc | gd, ~(ga & gb), ga & gb};
    if (flt == 2'd1) r[4] = 1'b0;
    if (flt == 2'd2) r[8] = slow_c;
    return r;
  endfunction

  always @(posedge clk) begin
    dly2 <= {dly2[1:0], c2};
    dly4 <= {dly4[1:0], c4};
    obs2 <= gate_model({a2, b2, c2, d2}, fault2, dly2[2]);
    obs4 <= gate_model({a4, b4, c4, d4}, fault4, dly4[2]);
  end

  typedef struct {
    string      tag;
    int         dut;
    logic [4:0] err;
    logic [3:0] ffv;
    logic [9:0] ffm;
    logic       pass;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic step_to(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic push_exp(input string tag, input int dut, input logic [4:0] e,
                          input logic [3:0] v, input logic [9:0] m, input logic p);
    exp_t x;
    x.tag = tag; x.dut = dut; x.err = e; x.ffv = v; x.ffm = m; x.pass = p;
    sb.push_back(x);
  endtask

  // Start both instances; cycle 0 is the cycle in which start is high.
  task automatic pulse_start();
    cyc   = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Wait for one instance to reach DONE, then score its run against the queue.
  task automatic finish_run(input int dut, input int budget);
    int   n;
    exp_t x;
    n = 0;
    while (!((dut == 2) ? done2 : done4) && n < budget) begin
      tick(1);
      n++;
    end
    if (sb.size() == 0) begin
      $display("FAIL scoreboard empty at dut%0d", dut);
      $fatal(1, "scoreboard underflow");
    end
    x = sb.pop_front();
    check({x.tag, "_done"}, 16'((dut == 2) ? done2 : done4), 16'd1);
    check({x.tag, "_dut"}, 16'(dut), 16'(x.dut));
    if (dut == 2) begin
      check({x.tag, "_err"}, 16'(err2), 16'(x.err));
      check({x.tag, "_ffv"}, 16'(ffv2), 16'(x.ffv));
      check({x.tag, "_ffm"}, 16'(ffm2), 16'(x.ffm));
      check({x.tag, "_pass"}, 16'(pass2), 16'(x.pass));
      $display("run %s dut2 err=%0d ffv=%0d ffm=%03h pass=%0b", x.tag, err2, ffv2, ffm2, pass2);
    end else begin
      check({x.tag, "_err"}, 16'(err4), 16'(x.err));
      check({x.tag, "_ffv"}, 16'(ffv4), 16'(x.ffv));
      check({x.tag, "_ffm"}, 16'(ffm4), 16'(x.ffm));
      check({x.tag, "_pass"}, 16'(pass4), 16'(x.pass));
      $display("run %s dut4 err=%0d ffv=%0d ffm=%03h pass=%0b", x.tag, err4, ffv4, ffm4, pass4);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy2"}, 16'(busy2), 16'd0);
    check({tag, "_done2"}, 16'(done2), 16'd0);
    check({tag, "_pass2"}, 16'(pass2), 16'd0);
    check({tag, "_err2"}, 16'(err2), 16'd0);
    check({tag, "_ffv2"}, 16'(ffv2), 16'd0);
    check({tag, "_ffm2"}, 16'(ffm2), 16'd0);
    check({tag, "_abcd2"}, 16'({a2, b2, c2, d2}), 16'd0);
    check({tag, "_busy4"}, 16'(busy4), 16'd0);
    check({tag, "_err4"}, 16'(err4), 16'd0);
    $display("reset %s checked", tag);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    fault2 = 2'd0;
    fault4 = 2'd0;
`ifdef GATE_CHECK_MASK_EN
    chk_mask = 10'd0;
`endif
    tick(3);
    rst = 1'b0;
    check_reset("por");

    // Correct gate block, with cycle-exact timing on the N=2 instance.
    push_exp("clean", 2, 5'd0, 4'd0, 10'h000, 1'b1);
    push_exp("clean", 4, 5'd0, 4'd0, 10'h000, 1'b1);
    pulse_start();
    check("clean_busy_c1", 16'(busy2), 16'd1);
    check("clean_abcd_c1", 16'({a2, b2, c2, d2}), 16'h0);
    step_to(5);
    check("clean_abcd_c5", 16'({a2, b2, c2, d2}), 16'h1);
    step_to(61);
    check("clean_abcd_c61", 16'({a2, b2, c2, d2}), 16'hF);
    step_to(64);
    check("clean_busy_c64", 16'(busy2), 16'd1);
    check("clean_done_c64", 16'(done2), 16'd0);
    step_to(65);
    check("clean_busy_c65", 16'(busy2), 16'd0);
    check("clean_done_c65", 16'(done2), 16'd1);
    check("clean_abcd_c65", 16'({a2, b2, c2, d2}), 16'h0);
    finish_run(2, 10);
    finish_run(4, 200);

    // o5 stuck at 0: fails on every odd-parity vector (8 of them).
    fault2 = 2'd1;
    fault4 = 2'd1;
    push_exp("o5stuck", 2, 5'd8, 4'd1, 10'h010, 1'b0);
    push_exp("o5stuck", 4, 5'd8, 4'd1, 10'h010, 1'b0);
    pulse_start();
    finish_run(2, 200);
    finish_run(4, 200);

    // o9 slow: with N=2 the sample still shows the previous vector's c, so each
    // vector where c differs from its predecessor fails (2,4,...,14). N=4 is enough.
    fault2 = 2'd2;
    fault4 = 2'd2;
    push_exp("o9slow", 2, 5'd7, 4'd2, 10'h100, 1'b0);
    push_exp("o9slow", 4, 5'd0, 4'd0, 10'h000, 1'b1);
    pulse_start();
    finish_run(2, 200);
    finish_run(4, 200);

    // Reset while the N=2 instance is on vector 7, then a fresh run.
    fault2 = 2'd1;
    fault4 = 2'd1;
    pulse_start();
    step_to(30);
    check("abort_abcd_c30", 16'({a2, b2, c2, d2}), 16'h7);
    check("abort_err_c30", 16'(err2), 16'd3);
    rst = 1'b1;
    start = 1'b1;
    tick(1);
    rst = 1'b0;
    start = 1'b0;
    check_reset("abort");
    push_exp("rerun", 2, 5'd8, 4'd1, 10'h010, 1'b0);
    push_exp("rerun", 4, 5'd8, 4'd1, 10'h010, 1'b0);
    pulse_start();
    finish_run(2, 200);
    finish_run(4, 200);

    // start held high: no restart while busy; restart the cycle after DONE.
    fault2 = 2'd0;
    fault4 = 2'd0;
    cyc = 0;
    start = 1'b1;
    tick(1);
    step_to(33);
    check("held_abcd_c33", 16'({a2, b2, c2, d2}), 16'h8);
    check("held_busy_c33", 16'(busy2), 16'd1);
    step_to(65);
    check("held_done_c65", 16'(done2), 16'd1);
    check("held_pass_c65", 16'(pass2), 16'd1);
    tick(1);
    start = 1'b0;
    check("held_busy_c66", 16'(busy2), 16'd1);
    check("held_done_c66", 16'(done2), 16'd0);
    check("held_abcd_c66", 16'({a2, b2, c2, d2}), 16'h0);
    push_exp("held", 4, 5'd0, 4'd0, 10'h000, 1'b1);
    push_exp("held", 2, 5'd0, 4'd0, 10'h000, 1'b1);
    finish_run(4, 200);
    finish_run(2, 200);

`ifdef GATE_CHECK_MASK_EN
    // o5 stuck at 0 but masked out of the comparison.
    fault2 = 2'd1;
    fault4 = 2'd1;
    chk_mask = 10'h010;
    push_exp("masked", 2, 5'd0, 4'd0, 10'h000, 1'b1);
    push_exp("masked", 4, 5'd0, 4'd0, 10'h000, 1'b1);
    pulse_start();
    finish_run(2, 200);
    finish_run(4, 200);
    chk_mask = 10'd0;
`endif

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
